// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// Optional leading-zero suppression is compiled in with SEG7_LZ_SUPPRESS_EN.
module seg7_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Value,
    input  logic        Load,
    input  logic [7:0]  DigitEn,
    output logic [6:0]  out7,
    output logic [7:0]  en_out,
    output logic [2:0]  DigitIdx,
    output logic        FrameDone,
    output logic        state_dbg
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      staging_q, staging_d;
    logic [31:0]      display_q, display_d;
    logic             pending_q, pending_d;
    logic [6:0]       out7_q, out7_d;
    logic [7:0]       en_out_q, en_out_d;
    logic             frame_done_q, frame_done_d;

    logic             slot_end;
    logic             frame_end;
    logic [7:0]       lit_mask;
    logic [3:0]       cur_nibble;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    always_comb begin
        slot_end  = (cnt_q == CNT_LAST);
        frame_end = slot_end && (idx_q == 3'd7);
        cnt_d     = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d     = slot_end ? idx_q + 3'd1 : idx_q;
    end

    // State tracks cnt against the blanking window; it leaves SHOW only on a slot wrap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BLANK: if (cnt_d >= CNT_BLANK) state_d = ST_SHOW;
            ST_SHOW:  if (slot_end && (cnt_d < CNT_BLANK)) state_d = ST_BLANK;
            default:  state_d = ST_BLANK;
        endcase
    end

`ifdef SEG7_LZ_SUPPRESS_EN
    logic [7:0] nib_nz;
    logic [7:0] lz_keep;

    // Digit i stays lit only if some nibble at or above i is non-zero; digit 0 always lit.
    always_comb begin
        nib_nz  = '0;
        lz_keep = '0;
        for (int i = 0; i < 8; i++) begin
            nib_nz[i] = |display_q[4*i +: 4];
        end
        for (int i = 1; i < 8; i++) begin
            lz_keep[i] = |(nib_nz >> i);
        end
        lz_keep[0] = 1'b1;
        lit_mask   = DigitEn & lz_keep;
    end
`else
    always_comb begin
        lit_mask = DigitEn;
    end
`endif

    always_comb begin
        cur_nibble   = display_q[{idx_q, 2'b00} +: 4];
        en_out_d     = 8'hFF;
        out7_d       = 7'h7F;
        frame_done_d = frame_end;
        if (state_q == ST_SHOW) begin
            en_out_d = ~(lit_mask & (8'h01 << idx_q));
            out7_d   = hex_to_seg(cur_nibble);
        end
    end

    // Load is a one-cycle strobe; display only moves on a frame boundary so a frame never tears.
    always_comb begin
        staging_d = Load ? Value : staging_q;
        display_d = display_q;
        pending_d = pending_q;
        if (frame_end) begin
            pending_d = 1'b0;
            if (Load) begin
                display_d = Value;
            end else if (pending_q) begin
                display_d = staging_q;
            end
        end else if (Load) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            staging_q    <= 32'h0;
            display_q    <= 32'h0;
            pending_q    <= 1'b0;
            out7_q       <= 7'h7F;
            en_out_q     <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            staging_q    <= staging_d;
            display_q    <= display_d;
            pending_q    <= pending_d;
            out7_q       <= out7_d;
            en_out_q     <= en_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out7      = out7_q;
    assign en_out    = en_out_q;
    assign DigitIdx  = idx_q;
    assign FrameDone = frame_done_q;
    assign state_dbg = (state_q == ST_SHOW);

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=4, BLANK_CYCLES=1 (32-cycle frames).
// Leading-zero expectations follow SEG7_LZ_SUPPRESS_EN when it is defined.
module tb_seg7_scan_driver;

    logic        Clk;
    logic        Reset;
    logic [31:0] Value;
    logic        Load;
    logic [7:0]  DigitEn;
    logic [6:0]  out7;
    logic [7:0]  en_out;
    logic [2:0]  DigitIdx;
    logic        FrameDone;
    logic        state_dbg;

    int tests     = 0;
    int fails     = 0;
    int cyc       = 0;
    int fd_pulses = 0;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg7_scan_driver #(
        .REFRESH_DIV (4),
        .BLANK_CYCLES(1)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Value    (Value),
        .Load     (Load),
        .DigitEn  (DigitEn),
        .out7     (out7),
        .en_out   (en_out),
        .DigitIdx (DigitIdx),
        .FrameDone(FrameDone),
        .state_dbg(state_dbg)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s @cyc %0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Runs one 32-cycle frame from a frame start and checks every output on every edge.
    task automatic check_frame(input logic [31:0] exp_val, input logic [7:0] exp_mask,
                               input int ld1_at, input logic [31:0] ld1_val,
                               input int ld2_at, input logic [31:0] ld2_val);
        int         pre;
        int         cnt;
        int         idx;
        logic       show;
        logic [7:0] exp_en;
        logic [6:0] exp_seg;
        for (int i = 0; i < 32; i++) begin
            if (i == ld1_at) begin
                Load  = 1'b1;
                Value = ld1_val;
            end else if (i == ld2_at) begin
                Load  = 1'b1;
                Value = ld2_val;
            end else begin
                Load = 1'b0;
            end
            tick();
            pre     = cyc - 1;
            cnt     = pre % 4;
            idx     = (pre / 4) % 8;
            show    = (cnt >= 1);
            exp_en  = (show && exp_mask[idx]) ? ~(8'h01 << idx) : 8'hFF;
            exp_seg = show ? seg_tab[exp_val[idx*4 +: 4]] : 7'h7F;
            chk("en_out", {24'h0, en_out}, {24'h0, exp_en});
            chk("out7", {25'h0, out7}, {25'h0, exp_seg});
            chk("frame_done", {31'h0, FrameDone}, {31'h0, (cyc % 32) == 0});
            chk("digit_idx", {29'h0, DigitIdx}, 32'((cyc / 4) % 8));
            chk("state", {31'h0, state_dbg}, {31'h0, (cyc % 4) >= 1});
            if (FrameDone) fd_pulses++;
        end
        Load = 1'b0;
    endtask

    initial begin
        Reset   = 1'b0;
        Value   = 32'h0;
        Load    = 1'b0;
        DigitEn = 8'hFF;

        // Reset held for three edges
        repeat (3) tick();
        chk("rst_en_out", {24'h0, en_out}, 32'hFF);
        chk("rst_out7", {25'h0, out7}, 32'h7F);
        chk("rst_frame_done", {31'h0, FrameDone}, 32'h0);
        chk("rst_digit_idx", {29'h0, DigitIdx}, 32'h0);
        chk("rst_state", {31'h0, state_dbg}, 32'h0);
        Reset = 1'b1;
        cyc   = 0;

        // Frame 1: display 0, mid-frame load of 0x000000F8 must wait for the boundary
        check_frame(32'h0000_0000, 8'hFF, 4, 32'h0000_00F8, -1, 32'h0);
        // Frame 2: shows F8; two loads, the last one wins
        check_frame(32'h0000_00F8, 8'hFF, 5, 32'h1111_1111, 20, 32'h2222_2222);
        // Frame 3: shows 2s; load on the boundary cycle itself
        check_frame(32'h2222_2222, 8'hFF, 31, 32'h3333_3333, -1, 32'h0);
        // Frame 4: bypassed value shows with no frame of delay
        check_frame(32'h3333_3333, 8'hFF, -1, 32'h0, -1, 32'h0);

        // Frames 5-6: only digits 0 and 2 enabled
        DigitEn   = 8'b0000_0101;
        fd_pulses = 0;
        check_frame(32'h3333_3333, 8'b0000_0101, -1, 32'h0, -1, 32'h0);
        check_frame(32'h3333_3333, 8'b0000_0101, 31, 32'h0000_0A05, -1, 32'h0);
        chk("frame_done_count", 32'(fd_pulses), 32'd2);

        // Frames 7-8: leading zeros, then value zero
        DigitEn = 8'hFF;
`ifdef SEG7_LZ_SUPPRESS_EN
        check_frame(32'h0000_0A05, 8'h07, 31, 32'h0, -1, 32'h0);
        check_frame(32'h0000_0000, 8'h01, -1, 32'h0, -1, 32'h0);
`else
        check_frame(32'h0000_0A05, 8'hFF, 31, 32'h0, -1, 32'h0);
        check_frame(32'h0000_0000, 8'hFF, -1, 32'h0, -1, 32'h0);
`endif

        // Reset asserted mid-frame with a load pending
        Load  = 1'b1;
        Value = 32'h9999_9999;
        tick();
        Load = 1'b0;
        repeat (4) tick();
        #2;
        Reset = 1'b0;
        #1;
        chk("mid_rst_en_out", {24'h0, en_out}, 32'hFF);
        chk("mid_rst_out7", {25'h0, out7}, 32'h7F);
        chk("mid_rst_frame_done", {31'h0, FrameDone}, 32'h0);
        chk("mid_rst_digit_idx", {29'h0, DigitIdx}, 32'h0);
        chk("mid_rst_state", {31'h0, state_dbg}, 32'h0);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        cyc   = 0;
        check_frame(32'h0000_0000, 8'hFF, -1, 32'h0, -1, 32'h0);
        check_frame(32'h0000_0000, 8'hFF, -1, 32'h0, -1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
